// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared Wishbone widths, arbiter state encoding and the
//               two-way round-robin pick function.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int WB_DATA_LEN      = 32;
    localparam int VIRTUAL_ADDR_LEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    // Winner id for two requesters: a lone request wins, a tie goes to the
    // requester that did not win last time.
    function automatic logic rr_pick(input logic i_req0, input logic i_req1,
                                     input logic i_last);
        rr_pick = (i_req0 & i_req1) ? ~i_last : ~i_req0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_rr_arb2
// Description : Two-way round-robin grant. The grant is combinational from
//               the requests; the last-grant history updates only when the
//               parent actually takes the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_rr_arb2 (
    input  logic clk,
    input  logic rstn,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_grant_valid,
    output logic o_grant_id
);
    import wb_arbiter_pkg::*;

    logic r_last_grant;

    // Current winner from the live requests and the grant history.
    always_comb begin
        o_grant_valid = i_req0 | i_req1;
        o_grant_id    = rr_pick(i_req0, i_req1, r_last_grant);
    end

    // History resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_last_grant <= 1'b1;
        end else if (i_take) begin
            r_last_grant <= o_grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Arbitrates two requesters onto one Wishbone classic master.
//               One outstanding transaction; every request (read or write)
//               returns exactly one response unless flushed; ack timeout
//               produces an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int WB_DATA_LEN      = wb_arbiter_pkg::WB_DATA_LEN,
    parameter int VIRTUAL_ADDR_LEN = wb_arbiter_pkg::VIRTUAL_ADDR_LEN,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush,
    // requester 0 (LSU router)
    input  logic                        req_valid_0,
    output logic                        req_ready_0,
    input  logic                        req_we_0,
    input  logic [VIRTUAL_ADDR_LEN-1:0] req_adr_0,
    input  logic [WB_DATA_LEN-1:0]      req_dat_0,
    input  logic [WB_DATA_LEN/8-1:0]    req_sel_0,
    output logic                        resp_valid_0,
    input  logic                        resp_ready_0,
    output logic [WB_DATA_LEN-1:0]      resp_dat_0,
    output logic                        resp_err_0,
    // requester 1 (fetch / PTW)
    input  logic                        req_valid_1,
    output logic                        req_ready_1,
    input  logic                        req_we_1,
    input  logic [VIRTUAL_ADDR_LEN-1:0] req_adr_1,
    input  logic [WB_DATA_LEN-1:0]      req_dat_1,
    input  logic [WB_DATA_LEN/8-1:0]    req_sel_1,
    output logic                        resp_valid_1,
    input  logic                        resp_ready_1,
    output logic [WB_DATA_LEN-1:0]      resp_dat_1,
    output logic                        resp_err_1,
    // Wishbone master
    output logic                        wb_cyc_o,
    output logic                        wb_stb_o,
    output logic                        wb_we_o,
    output logic [VIRTUAL_ADDR_LEN-1:0] wb_adr_o,
    output logic [WB_DATA_LEN-1:0]      wb_dat_o,
    output logic [WB_DATA_LEN/8-1:0]    wb_sel_o,
    input  logic                        wb_ack_i,
    input  logic [WB_DATA_LEN-1:0]      wb_dat_i
);
    import wb_arbiter_pkg::*;

    localparam int c_SEL_W = WB_DATA_LEN / 8;
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e                  r_state;
    logic                        r_gid;
    logic                        r_we;
    logic [VIRTUAL_ADDR_LEN-1:0] r_adr;
    logic [WB_DATA_LEN-1:0]      r_dat;
    logic [c_SEL_W-1:0]          r_sel;
    logic                        r_cyc;
    logic [c_CNT_W-1:0]          r_cnt;
    logic                        r_resp_valid_0;
    logic                        r_resp_valid_1;
    logic [WB_DATA_LEN-1:0]      r_resp_dat;
    logic                        r_resp_err;

    logic w_grant_valid;
    logic w_grant_id;
    logic w_open;
    logic w_take;
    logic w_bus_done;
    logic w_resp_hs;

    // Requests are only offered in IDLE, never while flushing or in reset.
    assign w_open      = (r_state == ST_IDLE) & ~flush & ~rstn;
    assign w_take      = w_open & w_grant_valid;
    assign req_ready_0 = w_take & ~w_grant_id;
    assign req_ready_1 = w_take &  w_grant_id;

    // Bus cycle ends on ack, or on the last allowed cycle without ack.
    assign w_bus_done = wb_ack_i | (r_cnt == c_CNT_LAST);
    assign w_resp_hs  = (r_resp_valid_0 & resp_ready_0) | (r_resp_valid_1 & resp_ready_1);

    wb_arbiter_rr_arb2 u_rr_arb2 (
        .clk           (clk),
        .rstn          (rstn),
        .i_req0        (req_valid_0),
        .i_req1        (req_valid_1),
        .i_take        (w_take),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Transaction FSM: latch request, run one classic cycle, return response.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state        <= ST_IDLE;
            r_gid          <= 1'b0;
            r_we           <= 1'b0;
            r_adr          <= '0;
            r_dat          <= '0;
            r_sel          <= '0;
            r_cyc          <= 1'b0;
            r_cnt          <= '0;
            r_resp_valid_0 <= 1'b0;
            r_resp_valid_1 <= 1'b0;
            r_resp_dat     <= '0;
            r_resp_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state <= ST_BUS;
                        r_gid   <= w_grant_id;
                        r_we    <= w_grant_id ? req_we_1  : req_we_0;
                        r_adr   <= w_grant_id ? req_adr_1 : req_adr_0;
                        r_dat   <= w_grant_id ? req_dat_1 : req_dat_0;
                        r_sel   <= w_grant_id ? req_sel_1 : req_sel_0;
                        r_cyc   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_BUS: begin
                    if (w_bus_done) begin
                        r_cyc <= 1'b0;
                        r_cnt <= '0;
                        // A flush coinciding with completion simply drops it.
                        if (flush) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state        <= ST_RESP;
                            r_resp_dat     <= (wb_ack_i & ~r_we) ? wb_dat_i : '0;
                            r_resp_err     <= ~wb_ack_i;
                            r_resp_valid_0 <= ~r_gid;
                            r_resp_valid_1 <=  r_gid;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (flush) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Finish the abandoned cycle on the bus, report nothing.
                    if (w_bus_done) begin
                        r_state <= ST_IDLE;
                        r_cyc   <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (flush | w_resp_hs) begin
                        r_state        <= ST_IDLE;
                        r_resp_valid_0 <= 1'b0;
                        r_resp_valid_1 <= 1'b0;
                        r_resp_dat     <= '0;
                        r_resp_err     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;

    assign resp_valid_0 = r_resp_valid_0;
    assign resp_valid_1 = r_resp_valid_1;
    assign resp_dat_0   = r_resp_valid_0 ? r_resp_dat : '0;
    assign resp_dat_1   = r_resp_valid_1 ? r_resp_dat : '0;
    assign resp_err_0   = r_resp_valid_0 & r_resp_err;
    assign resp_err_1   = r_resp_valid_1 & r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter: arbitration table,
//               directed multi-cycle sequences and a randomized run against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int D = 32;
    localparam int A = 32;
    localparam int S = 4;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         flush = 1'b0;
    logic         req_valid_0 = 1'b0, req_we_0 = 1'b0, resp_ready_0 = 1'b0;
    logic         req_valid_1 = 1'b0, req_we_1 = 1'b0, resp_ready_1 = 1'b0;
    logic [A-1:0] req_adr_0 = '0, req_adr_1 = '0;
    logic [D-1:0] req_dat_0 = '0, req_dat_1 = '0;
    logic [S-1:0] req_sel_0 = '0, req_sel_1 = '0;
    logic         req_ready_0, req_ready_1, resp_valid_0, resp_valid_1;
    logic         resp_err_0, resp_err_1;
    logic [D-1:0] resp_dat_0, resp_dat_1;
    logic         wb_cyc_o, wb_stb_o, wb_we_o;
    logic [A-1:0] wb_adr_o;
    logic [D-1:0] wb_dat_o;
    logic [S-1:0] wb_sel_o;
    logic         wb_ack_i = 1'b0;
    logic [D-1:0] wb_dat_i = '0;

    always #5 clk = ~clk;

    wb_arbiter #(.WB_DATA_LEN(D), .VIRTUAL_ADDR_LEN(A), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_adr_0(req_adr_0), .req_dat_0(req_dat_0), .req_sel_0(req_sel_0),
        .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
        .resp_dat_0(resp_dat_0), .resp_err_0(resp_err_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_adr_1(req_adr_1), .req_dat_1(req_dat_1), .req_sel_1(req_sel_1),
        .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
        .resp_dat_1(resp_dat_1), .resp_err_1(resp_err_1),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic fl, v0, v1, r0, r1;
    } vec_t;
    vec_t tbl [8];

    int   exp_g [4];
    int   grants [$];
    int   n, got;
    // reference-model state for the random run
    int   last_win, exp_win, bus_cnt, t_delay, wait_cyc, n_txn, exp_len;
    bit   have_txn, resp_first, exp_err;
    logic acc0, acc1, t_id, t_we;
    logic [A-1:0] t_adr;
    logic [D-1:0] t_dat, t_slv, exp_dat;
    logic [S-1:0] t_sel;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        // ---------------- reset state ----------------
        req_valid_0 = 1'b1;
        #2;
        chk("rst.cyc", wb_cyc_o, 0);
        chk("rst.stb", wb_stb_o, 0);
        chk("rst.ready0", req_ready_0, 0);
        chk("rst.rvalid", {resp_valid_1, resp_valid_0}, 0);
        chk("rst.adr", wb_adr_o, 0);
        chk("rst.rdat0", resp_dat_0, 0);
        req_valid_0 = 1'b0;
        step();
        step();
        rstn = 1'b0;

        // ---------------- IDLE arbitration table ----------------
        tbl[0] = '{fl:0, v0:0, v1:0, r0:0, r1:0};
        tbl[1] = '{fl:0, v0:1, v1:0, r0:1, r1:0};
        tbl[2] = '{fl:0, v0:0, v1:1, r0:0, r1:1};
        tbl[3] = '{fl:0, v0:1, v1:1, r0:1, r1:0};
        tbl[4] = '{fl:1, v0:0, v1:0, r0:0, r1:0};
        tbl[5] = '{fl:1, v0:1, v1:0, r0:0, r1:0};
        tbl[6] = '{fl:1, v0:0, v1:1, r0:0, r1:0};
        tbl[7] = '{fl:1, v0:1, v1:1, r0:0, r1:0};
        for (int i = 0; i < 8; i++) begin
            flush = tbl[i].fl; req_valid_0 = tbl[i].v0; req_valid_1 = tbl[i].v1;
            #1;
            chk($sformatf("tbl%0d.ready0", i), req_ready_0, tbl[i].r0);
            chk($sformatf("tbl%0d.ready1", i), req_ready_1, tbl[i].r1);
            chk($sformatf("tbl%0d.cyc", i), wb_cyc_o, 0);
            flush = 1'b0; req_valid_0 = 1'b0; req_valid_1 = 1'b0;
            step();
        end

        // flush and request across an edge: nothing accepted
        flush = 1'b1; req_valid_0 = 1'b1;
        step();
        flush = 1'b0; req_valid_0 = 1'b0;
        #1;
        chk("flush_idle.cyc", wb_cyc_o, 0);
        step();

        // ---------------- single load, ack on 3rd BUS cycle ----------------
        req_valid_0 = 1'b1; req_we_0 = 1'b0; req_adr_0 = 32'h8000_0010;
        req_dat_0 = 32'h0; req_sel_0 = 4'hF;
        #1;
        chk("load.ready0", req_ready_0, 1);
        step();
        req_valid_0 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            wb_ack_i = (c == 3);
            wb_dat_i = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            chk($sformatf("load.cyc%0d", c), {wb_cyc_o, wb_stb_o}, 2'b11);
            chk($sformatf("load.rvalid%0d", c), resp_valid_0, 0);
            if (c == 1) begin
                chk("load.adr", wb_adr_o, 32'h8000_0010);
                chk("load.sel", wb_sel_o, 4'hF);
                chk("load.we", wb_we_o, 0);
            end
            step();
        end
        wb_ack_i = 1'b0;
        // response held while not accepted; requester 1 must wait
        req_valid_1 = 1'b1; resp_ready_0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("hold%0d.rvalid0", k), resp_valid_0, 1);
            chk($sformatf("hold%0d.rdat0", k), resp_dat_0, 32'hDEAD_BEEF);
            chk($sformatf("hold%0d.err0", k), resp_err_0, 0);
            chk($sformatf("hold%0d.ready1", k), req_ready_1, 0);
            chk($sformatf("hold%0d.cyc", k), wb_cyc_o, 0);
            step();
        end
        resp_ready_0 = 1'b1;
        #1;
        chk("hold.final_rvalid0", resp_valid_0, 1);
        step();
        resp_ready_0 = 1'b0;
        #1;
        chk("hold.after_rvalid0", resp_valid_0, 0);
        chk("hold.after_ready1", req_ready_1, 1);
        req_valid_1 = 1'b0;
        step();

        // ---------------- write with no ack: timeout ----------------
        req_valid_1 = 1'b1; req_we_1 = 1'b1; req_adr_1 = 32'h100;
        req_dat_1 = 32'h1234_5678; req_sel_1 = 4'h3;
        #1;
        chk("to.ready1", req_ready_1, 1);
        step();
        req_valid_1 = 1'b0;
        n = 0; got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            #1;
            if (wb_cyc_o) begin
                n++;
                if (n == 1) begin
                    chk("to.we", wb_we_o, 1);
                    chk("to.adr", wb_adr_o, 32'h100);
                    chk("to.dat", wb_dat_o, 32'h1234_5678);
                    chk("to.sel", wb_sel_o, 4'h3);
                end
            end
            if (resp_valid_1) begin
                got = 1;
                chk("to.err1", resp_err_1, 1);
                chk("to.rdat1", resp_dat_1, 0);
                chk("to.rvalid0", resp_valid_0, 0);
                resp_ready_1 = 1'b1;
            end
            step();
        end
        resp_ready_1 = 1'b0;
        chk("to.cyc_cycles", n, T);
        chk("to.resp_seen", got, 1);

        // ---------------- both requesting, immediate ack ----------------
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1; req_we_0 = 1'b0; req_we_1 = 1'b0;
        req_adr_0 = 32'hA0; req_adr_1 = 32'hB0;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        for (int c = 0; c < 60 && grants.size() < 4; c++) begin
            wb_ack_i = wb_cyc_o;
            #1;
            if (req_ready_0 && req_valid_0) grants.push_back(0);
            else if (req_ready_1 && req_valid_1) grants.push_back(1);
            step();
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        chk("rr.count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++)
            chk($sformatf("rr.grant%0d", i), grants[i], exp_g[i]);
        for (int c = 0; c < 6; c++) begin
            wb_ack_i = wb_cyc_o;
            step();
        end
        wb_ack_i = 1'b0; resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;

        // ---------------- flush during BUS ----------------
        req_valid_0 = 1'b1; req_adr_0 = 32'h200;
        #1;
        chk("fl.ready0", req_ready_0, 1);
        step();
        req_valid_0 = 1'b0; flush = 1'b1;
        #1;
        chk("fl.cyc1", wb_cyc_o, 1);
        step();
        flush = 1'b0;
        #1;
        chk("fl.cyc2", wb_cyc_o, 1);
        chk("fl.rvalid2", resp_valid_0, 0);
        step();
        wb_ack_i = 1'b1;
        #1;
        chk("fl.cyc3", wb_cyc_o, 1);
        step();
        wb_ack_i = 1'b0;
        #1;
        chk("fl.cyc4", wb_cyc_o, 0);
        chk("fl.rvalid4", resp_valid_0, 0);
        req_valid_0 = 1'b1; req_adr_0 = 32'h300;
        #1;
        chk("fl.next_ready0", req_ready_0, 1);
        step();
        req_valid_0 = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h55AA;
        #1;
        chk("fl.next_adr", wb_adr_o, 32'h300);
        step();
        wb_ack_i = 1'b0;
        #1;
        chk("fl.next_rvalid", resp_valid_0, 1);
        chk("fl.next_rdat", resp_dat_0, 32'h55AA);
        resp_ready_0 = 1'b1;
        step();
        resp_ready_0 = 1'b0;

        // ---------------- flush during RESP ----------------
        req_valid_1 = 1'b1; req_we_1 = 1'b0; req_adr_1 = 32'h400;
        step();
        req_valid_1 = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h77;
        step();
        wb_ack_i = 1'b0; flush = 1'b1;
        #1;
        chk("flr.rvalid1", resp_valid_1, 1);
        step();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("flr.gone%0d", c), resp_valid_1, 0);
            step();
        end

        // ---------------- reset mid-BUS, stale ack ----------------
        req_valid_1 = 1'b1; req_adr_1 = 32'h500;
        step();
        req_valid_1 = 1'b0;
        #1;
        chk("rb.cyc_before", wb_cyc_o, 1);
        rstn = 1'b1;
        #1;
        chk("rb.cyc_in_reset", {wb_cyc_o, wb_stb_o}, 0);
        step();
        step();
        rstn = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'hBAD;
        #1;
        chk("rb.cyc_after", wb_cyc_o, 0);
        step();
        wb_ack_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rb.noresp%0d", c), {resp_valid_1, resp_valid_0, wb_cyc_o}, 0);
            step();
        end
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        #1;
        chk("rb.tie", {req_ready_1, req_ready_0}, 2'b01);
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        step();

        // ---------------- randomized run vs transaction model ----------------
        last_win = 1; have_txn = 0; n_txn = 0; bus_cnt = 0; wait_cyc = 0;
        t_delay = 0; resp_first = 0;
        t_id = 0; t_we = 0; t_adr = '0; t_dat = '0; t_sel = '0; t_slv = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!req_valid_0 && $urandom_range(2) == 0) begin
                req_valid_0 = 1'b1; req_we_0 = 1'($urandom); req_adr_0 = $urandom;
                req_dat_0 = $urandom; req_sel_0 = 4'($urandom);
            end
            if (!req_valid_1 && $urandom_range(2) == 0) begin
                req_valid_1 = 1'b1; req_we_1 = 1'($urandom); req_adr_1 = $urandom;
                req_dat_1 = $urandom; req_sel_1 = 4'($urandom);
            end
            resp_ready_0 = 1'($urandom_range(1));
            resp_ready_1 = 1'($urandom_range(1));
            if (wb_cyc_o) begin
                wb_ack_i = (bus_cnt == t_delay);
                wb_dat_i = t_slv;
            end else begin
                wb_ack_i = ($urandom_range(3) == 0);
                wb_dat_i = $urandom;
            end
            #1;
            chk("rnd.two_ready", req_ready_0 & req_ready_1, 0);
            acc0 = req_valid_0 & req_ready_0;
            acc1 = req_valid_1 & req_ready_1;
            if (acc0 | acc1) begin
                chk("rnd.accept_busy", have_txn, 0);
                exp_win = (req_valid_0 && req_valid_1) ? 1 - last_win : (req_valid_0 ? 0 : 1);
                chk("rnd.winner", acc1, exp_win);
                t_id  = acc1;
                t_we  = acc1 ? req_we_1  : req_we_0;
                t_adr = acc1 ? req_adr_1 : req_adr_0;
                t_dat = acc1 ? req_dat_1 : req_dat_0;
                t_sel = acc1 ? req_sel_1 : req_sel_0;
                t_delay = $urandom_range(5);
                t_slv = $urandom;
                bus_cnt = 0; have_txn = 1; resp_first = 1; wait_cyc = 0;
                last_win = acc1 ? 1 : 0;
                n_txn++;
            end
            if (wb_cyc_o) begin
                chk("rnd.cyc_txn", have_txn, 1);
                chk("rnd.adr", wb_adr_o, t_adr);
                chk("rnd.we", wb_we_o, t_we);
                chk("rnd.dat", wb_dat_o, t_dat);
                chk("rnd.sel", wb_sel_o, t_sel);
                bus_cnt++;
            end
            if (resp_valid_0 | resp_valid_1) begin
                chk("rnd.resp_txn", have_txn, 1);
                chk("rnd.resp_port", {resp_valid_1, resp_valid_0}, t_id ? 2'b10 : 2'b01);
                exp_err = (t_delay >= T);
                exp_dat = (exp_err || t_we) ? '0 : t_slv;
                chk("rnd.rdat", t_id ? resp_dat_1 : resp_dat_0, exp_dat);
                chk("rnd.rerr", t_id ? resp_err_1 : resp_err_0, exp_err);
                if (resp_first) begin
                    exp_len = (t_delay + 1 < T) ? t_delay + 1 : T;
                    chk("rnd.bus_len", bus_cnt, exp_len);
                    resp_first = 0;
                end
                if (t_id ? (resp_valid_1 & resp_ready_1) : (resp_valid_0 & resp_ready_0))
                    have_txn = 0;
            end
            if (have_txn) wait_cyc++;
            if (wait_cyc > 40) begin
                total++; bad++;
                $display("FAIL rnd.watchdog: got %0d cycles want <= 40", wait_cyc);
                break;
            end
            step();
            if (acc0) req_valid_0 = 1'b0;
            if (acc1) req_valid_1 = 1'b0;
        end
        chk("rnd.progress", n_txn > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter WB_DATA_LEN, default 32, Wishbone data width (shared package value).
REQ-002 Parameter VIRTUAL_ADDR_LEN, default from shared package, address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max cycles waiting for wb_ack_i before error.
REQ-004 Clock: clk  input  1  one clock; all logic on rising edge.
REQ-005 Reset: rstn  input  1  reset is asynchronous and active-high (asserted = 1, despite the name).
REQ-006 flush  input  1  drop pending responses; see REQ-019.
REQ-007 Per requester n in {0,1} (0 = LSU router, 1 = fetch/PTW): req_valid_n  input  1; req_ready_n  output  1; req_we_n  input  1; req_adr_n  input  VIRTUAL_ADDR_LEN; req_dat_n  input  WB_DATA_LEN; req_sel_n  input  WB_DATA_LEN/8.
REQ-008 Per requester n: resp_valid_n  output  1; resp_ready_n  input  1; resp_dat_n  output  WB_DATA_LEN; resp_err_n  output  1 (timeout).
REQ-009 Master: wb_cyc_o, wb_stb_o, wb_we_o  output  1; wb_adr_o  output  VIRTUAL_ADDR_LEN; wb_dat_o  output  WB_DATA_LEN; wb_sel_o  output  WB_DATA_LEN/8; wb_ack_i  input  1; wb_dat_i  input  WB_DATA_LEN.

Function
REQ-010 FSM states IDLE, BUS, RESP, DRAIN; reset state IDLE.
REQ-011 IDLE: req_ready_n = 1 only for the grant winner; all other ready/valid outputs 0.
REQ-012 Arbitration round-robin: single valid wins; both valid -> requester other than last_grant wins; last_grant resets to 1 (so requester 0 wins first tie).
REQ-013 Accepted request (valid & ready in IDLE) registers we/adr/dat/sel and grant id, updates last_grant, next state BUS; no combinational path from req_* to wb_*.
REQ-014 BUS: wb_cyc_o = wb_stb_o = 1, wb_* driven from registers; timeout counter starts at 0, +1 per cycle without ack.
REQ-015 BUS with wb_ack_i: capture wb_dat_i (write: capture 0), err = 0, cyc/stb drop next cycle, next state RESP; minimum request-to-response latency 2 cycles (accept edge, ack edge).
REQ-016 BUS with counter == TIMEOUT_CYCLES-1 and no ack: drop cyc/stb, err = 1, data = 0, next state RESP; ack in the same cycle wins over timeout.
REQ-017 RESP: resp_valid_g = 1 for granted requester g only, dat/err held stable until resp_ready_g; on handshake -> IDLE; new request may be accepted the cycle after.
REQ-018 Writes also return a response (resp_dat = 0) so requesters count completions.
REQ-019 flush: in IDLE no effect; in RESP -> IDLE next cycle, response discarded; in BUS -> DRAIN (cyc/stb kept until ack or timeout, then IDLE with no response); flush in DRAIN has no effect.
REQ-020 Flush and accept in the same IDLE cycle: flush wins, no request accepted, req_ready outputs 0 while flush = 1.
REQ-021 Wishbone single classic cycles only; no bursts, no retry, no wb_err_i.

Reset
REQ-022 Asserting rstn forces IDLE asynchronously; all outputs 0, counter 0, registered request 0, last_grant = 1.
REQ-023 Reset mid-BUS abandons the cycle immediately (cyc/stb 0); a later stale ack in IDLE is ignored.

Structure
REQ-024 WB_DATA_LEN, VIRTUAL_ADDR_LEN and the FSM state enum live in the shared params package.
REQ-025 One sub-module natural: rr_arb2 (2-way round-robin grant, last_grant register inside).

Verification
REQ-026 Single load req0 adr 0x8000_0010 sel 0xF; slave acks at 3rd BUS cycle with 0xDEADBEEF -> resp_valid_0 with 0xDEADBEEF, err 0, 4 cycles after accept.
REQ-027 req0 and req1 valid continuously, immediate ack -> grants alternate 0,1,0,1; no back-to-back grant to one port.
REQ-028 Write req1 adr 0x100 dat 0x12345678 sel 0x3, no ack; TIMEOUT_CYCLES = 4 -> cyc high exactly 4 cycles, resp_err_1 = 1, resp_dat_1 = 0.
REQ-029 flush in BUS, ack 2 cycles later -> cyc held until ack, no resp_valid, then IDLE accepts next request.
REQ-030 resp_ready_0 held low 5 cycles in RESP -> resp_valid_0/dat stable, no new grant until handshake.
REQ-031 rstn asserted mid-BUS then ack pulse after release -> wb_cyc_o 0 during reset, stale ack produces no response.
